// File: rtl/chroma_dc_quantise_pkg.sv
// rtl/chroma_dc_quantise_pkg.sv - shared constants, types and lookups for chroma DC quantisation
//
// Purpose : multiplier table, rounding-term table, block state enum and
//           datapath widths shared by chroma_dc_quantise and quant_scale_pipe.
// Ports   : none (package).

package chroma_dc_quantise_pkg;

  localparam int LEVEL_W = 12;  // quantised level width
  localparam int MAG_W   = 17;  // |c| width; holds |-32768| exactly
  localparam int PROD_W  = 31;  // |c| * MF

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [13:0] MF_TABLE [6] = '{
    14'd13107, 14'd11916, 14'd10082, 14'd9362, 14'd8192, 14'd7282
  };

  function automatic logic [13:0] mf_lookup(input logic [2:0] qp_mod6);
    case (qp_mod6)
      3'd0:    return MF_TABLE[0];
      3'd1:    return MF_TABLE[1];
      3'd2:    return MF_TABLE[2];
      3'd3:    return MF_TABLE[3];
      3'd4:    return MF_TABLE[4];
      3'd5:    return MF_TABLE[5];
      default: return MF_TABLE[0];
    endcase
  endfunction

  // 2 * floor(2^qbits / 3) with qbits = 15 + qp_div6 (intra rounding).
  // Entries above 8 only matter for out-of-range QP and are kept for
  // deterministic behaviour.
  function automatic logic [31:0] round_term(input logic [3:0] qp_div6);
    case (qp_div6)
      4'd0:    return 32'd21844;
      4'd1:    return 32'd43690;
      4'd2:    return 32'd87380;
      4'd3:    return 32'd174762;
      4'd4:    return 32'd349524;
      4'd5:    return 32'd699050;
      4'd6:    return 32'd1398100;
      4'd7:    return 32'd2796202;
      4'd8:    return 32'd5592404;
      4'd9:    return 32'd11184810;
      4'd10:   return 32'd22369620;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/chroma_dc_quantise_quant_scale_pipe.sv
// rtl/chroma_dc_quantise_quant_scale_pipe.sv - multiply and round/shift stages of the DC quantiser
//
// Purpose : stage 2 registers |c|*MF; stage 3 adds the rounding term,
//           shifts by qbits+1, restores the sign and sizes to 12 bits.
//           Build option CHROMA_DC_QUANT_SAT_EN saturates to -2048..2047,
//           otherwise the level wraps to its low 12 bits.
// Ports   : CLK2, RESET       clock, synchronous active-high reset
//           in_valid          stage 1 holds a coefficient
//           in_mag/in_neg     |c| and sign of the coefficient
//           in_div6/in_mod6   latched QP/6 and QP%6
//           out_valid         one-cycle strobe per level
//           out_level         signed quantised level

module quant_scale_pipe
  import chroma_dc_quantise_pkg::*;
(
  input  logic               CLK2,
  input  logic               RESET,
  input  logic               in_valid,
  input  logic [MAG_W-1:0]   in_mag,
  input  logic               in_neg,
  input  logic [3:0]         in_div6,
  input  logic [2:0]         in_mod6,
  output logic               out_valid,
  output logic [LEVEL_W-1:0] out_level
);

  logic              s2_valid;
  logic [PROD_W-1:0] s2_prod;
  logic              s2_neg;
  logic [3:0]        s2_div6;

  logic [31:0]        sum;
  logic [4:0]         shamt;
  logic [31:0]        shifted;
  logic [LEVEL_W-1:0] level_c;

  always_ff @(posedge CLK2) begin
    if (RESET) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_neg   <= 1'b0;
      s2_div6  <= '0;
    end else begin
      s2_valid <= in_valid;
      s2_prod  <= {14'd0, in_mag} * {17'd0, mf_lookup(in_mod6)};
      s2_neg   <= in_neg;
      s2_div6  <= in_div6;
    end
  end

  always_comb begin
    sum     = {1'b0, s2_prod} + round_term(s2_div6);
    shamt   = 5'd16 + {1'b0, s2_div6};
    shifted = sum >> shamt;
`ifdef CHROMA_DC_QUANT_SAT_EN
    // A magnitude of 2048 or more clamps; -2048 itself is representable.
    if (|shifted[31:11])
      level_c = s2_neg ? 12'h800 : 12'h7FF;
    else
      level_c = s2_neg ? (12'd0 - {1'b0, shifted[10:0]}) : {1'b0, shifted[10:0]};
`else
    // Negating a zero magnitude gives zero, so no negative zero appears.
    level_c = s2_neg ? (12'd0 - shifted[11:0]) : shifted[11:0];
`endif
  end

`ifndef CHROMA_DC_QUANT_SAT_EN
  logic unused_hi;
  assign unused_hi = ^shifted[31:12];
`endif

  always_ff @(posedge CLK2) begin
    if (RESET) begin
      out_valid <= 1'b0;
      out_level <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid)
        out_level <= level_c;
    end
  end

endmodule

// File: rtl/chroma_dc_quantise.sv
// rtl/chroma_dc_quantise.sv - chroma 2x2 DC coefficient quantiser with block handshake
//
// Purpose : accepts four DC coefficients per block, quantises each with the
//           QP latched at the first one, and reports the nonzero count with
//           the last level. Fixed three-stage pipeline, no internal stall.
//           Build option CHROMA_DC_QUANT_SAT_EN selects level saturation.
// Ports   : CLK2     clock                 RESET   sync active-high reset
//           ENABLE   coefficient strobe    XXIN    signed coefficient (16)
//           QP       chroma QP (6)         READYI  coefficient may be accepted
//           VALID    level strobe          YYOUT   signed level (12)
//           NZVALID  last level of block   NZCOUNT nonzero levels in block (3)

module chroma_dc_quantise
  import chroma_dc_quantise_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic               CLK2,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [15:0]        XXIN,
  input  logic [5:0]         QP,
  output logic               READYI,
  output logic               VALID,
  output logic [LEVEL_W-1:0] YYOUT,
  output logic               NZVALID,
  output logic [2:0]         NZCOUNT
);

  // DRAIN ends on the edge that loads the 4th level into the output register.
  localparam logic [1:0] DRAIN_LAST = 2'(LATENCY - 2);

  state_t     state, state_nxt;
  logic       ready_c;
  logic       accept;
  logic [1:0] in_idx;
  logic [1:0] drain_cnt;
  logic [5:0] qp_lat;
  logic [5:0] qp_eff;
  logic [3:0] qp_div6;
  logic [2:0] qp_mod6;
  logic [MAG_W-1:0] xx_ext;
  logic [MAG_W-1:0] mag_c;

  logic             s1_valid;
  logic [MAG_W-1:0] s1_mag;
  logic             s1_neg;
  logic [3:0]       s1_div6;
  logic [2:0]       s1_mod6;

  logic [1:0] out_idx;
  logic [2:0] nz_acc;
  logic [2:0] nz_base;
  logic       nz_bit;
  logic [2:0] nz_sum;

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b1;
    case (state)
      IDLE:  if (ENABLE) state_nxt = FILL;
      FILL:  if (ENABLE && in_idx == 2'd3) state_nxt = DRAIN;
      DRAIN: begin
        ready_c = 1'b0;
        if (drain_cnt == DRAIN_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign READYI = ready_c;
  assign accept = ENABLE && ready_c;

  // The first coefficient of a block uses the live QP; the rest use the latch.
  assign qp_eff  = (in_idx == 2'd0) ? QP : qp_lat;
  assign qp_div6 = 4'(qp_eff / 6'd6);
  assign qp_mod6 = 3'(qp_eff % 6'd6);

  // Extend before negating so |-32768| does not overflow.
  assign xx_ext = {XXIN[15], XXIN};
  assign mag_c  = XXIN[15] ? (17'd0 - xx_ext) : xx_ext;

  always_ff @(posedge CLK2) begin
    if (RESET) begin
      state     <= IDLE;
      in_idx    <= 2'd0;
      drain_cnt <= 2'd0;
      qp_lat    <= 6'd0;
      s1_valid  <= 1'b0;
      s1_mag    <= '0;
      s1_neg    <= 1'b0;
      s1_div6   <= '0;
      s1_mod6   <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      s1_valid  <= accept;
      if (accept) begin
        in_idx  <= in_idx + 2'd1;
        s1_mag  <= mag_c;
        s1_neg  <= XXIN[15];
        s1_div6 <= qp_div6;
        s1_mod6 <= qp_mod6;
        if (in_idx == 2'd0)
          qp_lat <= QP;
      end
    end
  end

  quant_scale_pipe u_scale (
    .CLK2      (CLK2),
    .RESET     (RESET),
    .in_valid  (s1_valid),
    .in_mag    (s1_mag),
    .in_neg    (s1_neg),
    .in_div6   (s1_div6),
    .in_mod6   (s1_mod6),
    .out_valid (VALID),
    .out_level (YYOUT)
  );

  // Running count restarts with the first level of each block so that the
  // 4th level's contribution is included in the value shown with NZVALID.
  assign nz_bit  = VALID && (YYOUT != '0);
  assign nz_base = (out_idx == 2'd0) ? 3'd0 : nz_acc;
  assign nz_sum  = nz_base + {2'b00, nz_bit};

  always_ff @(posedge CLK2) begin
    if (RESET) begin
      out_idx <= 2'd0;
      nz_acc  <= 3'd0;
    end else if (VALID) begin
      out_idx <= out_idx + 2'd1;
      nz_acc  <= nz_sum;
    end
  end

  assign NZVALID = VALID && (out_idx == 2'd3);
  assign NZCOUNT = nz_sum;

endmodule

// File: tb/tb_chroma_dc_quantise.sv
// tb/tb_chroma_dc_quantise.sv - self-checking bench for chroma_dc_quantise

module tb_chroma_dc_quantise;

  logic        CLK2 = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic [15:0] XXIN = '0;
  logic [5:0]  QP = '0;
  logic        READYI;
  logic        VALID;
  logic [11:0] YYOUT;
  logic        NZVALID;
  logic [2:0]  NZCOUNT;

  chroma_dc_quantise #(.LATENCY(3)) dut (
    .CLK2    (CLK2),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .XXIN    (XXIN),
    .QP      (QP),
    .READYI  (READYI),
    .VALID   (VALID),
    .YYOUT   (YYOUT),
    .NZVALID (NZVALID),
    .NZCOUNT (NZCOUNT)
  );

  always #5 CLK2 = ~CLK2;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int lvl;
    int due;
    bit last;
    int nz;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   inited = 0;
  bit   m_drain = 0;
  int   m_drain_end = 0;
  int   m_idx = 0;
  int   m_qp = 0;
  int   blk_nz = 0;
  int   n_valid = 0;

  function automatic longint mf_of(int r);
    case (r)
      0: return 13107;
      1: return 11916;
      2: return 10082;
      3: return 9362;
      4: return 8192;
      default: return 7282;
    endcase
  endfunction

  // level = sign(c) * ((|c|*MF + 2f) >> (qbits+1)), then sized to 12 bits
  function automatic int ref_level(int c, int qp);
    longint mag, f, l;
    int qb;
    mag = (c < 0) ? -c : c;
    qb  = 15 + qp / 6;
    f   = (longint'(1) << qb) / 3;
    l   = (mag * mf_of(qp % 6) + 2 * f) >> (qb + 1);
    if (c < 0) l = -l;
`ifdef CHROMA_DC_QUANT_SAT_EN
    if (l > 2047) l = 2047;
    if (l < -2048) l = -2048;
`else
    l = l & 64'hFFF;
    if (l >= 2048) l = l - 4096;
`endif
    return int'(l);
  endfunction

  // Reference model: decides acceptance from its own view of block progress.
  initial forever begin
    exp_t e;
    @(posedge CLK2);
    cyc++;
    if (RESET) begin
      q.delete();
      m_idx   = 0;
      m_drain = 0;
      blk_nz  = 0;
      inited  = 1;
    end else if (inited && ENABLE && !m_drain) begin
      if (m_idx == 0) m_qp = int'(QP);
      e.lvl  = ref_level(int'($signed(XXIN)), m_qp);
      blk_nz += (e.lvl != 0) ? 1 : 0;
      e.due  = cyc + 2;
      e.last = (m_idx == 3);
      e.nz   = blk_nz;
      q.push_back(e);
      if (m_idx == 3) begin
        m_drain     = 1;
        m_drain_end = cyc + 2;
        blk_nz      = 0;
      end
      m_idx = (m_idx + 1) % 4;
    end else if (m_drain && cyc >= m_drain_end) begin
      m_drain = 0;
    end
  end

  // Output checker, sampled mid-cycle.
  initial forever begin
    exp_t e;
    @(negedge CLK2);
    if (inited) begin
      check("readyi", READYI, !m_drain);
      if (VALID) begin
        n_valid++;
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("valid_latency", cyc, e.due);
          check("yyout", int'($signed(YYOUT)), e.lvl);
          check("nzvalid", NZVALID, e.last);
          if (e.last) check("nzcount", NZCOUNT, e.nz);
        end
      end else begin
        check("nzvalid_quiet", NZVALID, 0);
        if (q.size() > 0 && cyc >= q[0].due) begin
          check("missing_valid", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit en, input int x, input int qp);
    ENABLE = en;
    XXIN   = 16'(x);
    QP     = 6'(qp);
    @(posedge CLK2);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, int'($urandom), int'(QP));
  endtask

  initial begin
    int v0;
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_valid", VALID, 0);
    check("rst_nzvalid", NZVALID, 0);
    check("rst_yyout", YYOUT, 0);
    check("rst_nzcount", NZCOUNT, 0);
    check("rst_readyi", READYI, 1);
    RESET = 1'b0;
    step(0, 0, 0);
    check("ready_after_rst", READYI, 1);

    // QP=28 reference block
    step(1, 1000, 28); step(1, -1000, 28); step(1, 0, 28); step(1, 7, 28);
    idle(3);

    // QP change mid-block is ignored
    step(1, 20000, 28); step(1, -5000, 28); step(1, 3000, 0); step(1, -30000, 0);
    idle(3);

    // extremes at QP=0 and QP=51
    step(1, 32767, 0); step(1, -32768, 0); step(1, 0, 0); step(1, -1, 0);
    idle(3);
    step(1, 32767, 51); step(1, -32768, 51); step(1, 100, 51); step(1, -100, 51);
    idle(3);

    // ENABLE held high: two blocks, stalled during drain
    v0 = n_valid;
    for (int i = 0; i < 10; i++) step(1, int'($urandom), int'($urandom_range(0, 51)));
    idle(4);
    check("hold_valids", n_valid - v0, 8);

    // reset after two accepts, then a new block with a different QP
    step(1, 111, 10); step(1, 222, 10);
    RESET = 1'b1;
    step(0, 0, 10);
    RESET = 1'b0;
    check("rst_mid_readyi", READYI, 1);
    v0 = n_valid;
    idle(4);
    check("rst_mid_no_valid", n_valid - v0, 0);
    step(1, 5000, 40); step(1, -7000, 40); step(1, 30000, 40); step(1, -3, 40);
    idle(3);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      RESET = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 9) < 7, int'($urandom), int'($urandom_range(0, 51)));
    end
    RESET = 1'b0;
    idle(6);
    check("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
